// File: rtl/supercpu_dma_pkg.sv
// Shared definitions for the C64-side DMA master: byte lanes, error bits, direction encoding.
package supercpu_dma_pkg;

    localparam int unsigned DMA_BYTE_LANES = 4;

    typedef logic [1:0] lane_t;

    localparam int unsigned ERR_OVF = 0;
    localparam int unsigned ERR_UDF = 1;

    typedef enum logic {
        DIR_SYS_TO_C64 = 1'b0,
        DIR_C64_TO_SYS = 1'b1
    } dma_dir_e;

    // Little-endian lane select: lane 0 is bits [7:0].
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input lane_t lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dma_fifo_ram.sv
// Simple dual-port word store: synchronous write, asynchronous read (maps onto MLAB).
module dma_fifo_ram
    import supercpu_dma_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 16,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dma_byte_fifo.sv
// Sys->C64 word-in / byte-out FWFT FIFO with byte occupancy and flush.
// Optional DMA_BYTE_FIFO_STATS_EN adds sticky overflow/underflow flags and a peak level.
module dma_byte_fifo
    import supercpu_dma_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 16,
    localparam int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_valid,
    input  logic [31:0]       wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [7:0]        rd_data,
    input  logic              rd_pop,
    output logic [ADDR_W+2:0] level_bytes,
    output logic              empty
`ifdef DMA_BYTE_FIFO_STATS_EN
    ,
    output logic [1:0]        err_sticky,
    output logic [ADDR_W+2:0] peak_level
`endif
);

    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    lane_t             r_lane;
    logic [ADDR_W+2:0] r_level;
    logic [7:0]        r_rd_data;

    logic [ADDR_W:0]   w_wr_ptr_d;
    logic [ADDR_W:0]   w_rd_ptr_d;
    lane_t             w_lane_d;
    logic [ADDR_W+2:0] w_level_d;
    logic [7:0]        w_rd_data_d;
    logic [ADDR_W:0]   w_used_words;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_fire;
    logic              w_pop;
    logic              w_bypass;
    logic [31:0]       w_ram_rdata;
    logic [31:0]       w_head_word;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                     (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

    assign w_wr_fire = wr_valid && !w_full && !flush;
    assign w_pop     = rd_pop && !w_empty && !flush;

    dma_fifo_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_ram (
        .i_clk   (clk_sys),
        .i_we    (w_wr_fire),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (wr_data),
        .i_raddr (w_rd_ptr_d[ADDR_W-1:0]),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        w_lane_d   = r_lane;
        if (flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_lane_d   = '0;
        end else begin
            if (w_wr_fire) begin
                w_wr_ptr_d = r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                if (r_lane == lane_t'(DMA_BYTE_LANES - 1)) begin
                    w_lane_d   = '0;
                    w_rd_ptr_d = r_rd_ptr + 1'b1;
                end else begin
                    w_lane_d = r_lane + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_used_words = w_wr_ptr_d - w_rd_ptr_d;
        w_level_d    = {w_used_words, 2'b00} - {{(ADDR_W + 1){1'b0}}, w_lane_d};
        // A word landing in the slot that becomes the head is not yet visible in the RAM.
        w_bypass     = w_wr_fire && (r_wr_ptr == w_rd_ptr_d);
        w_head_word  = w_bypass ? wr_data : w_ram_rdata;
        w_rd_data_d  = flush ? 8'h00 : lane_byte(w_head_word, w_lane_d);
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_lane    <= '0;
            r_level   <= '0;
            r_rd_data <= '0;
        end else begin
            r_wr_ptr  <= w_wr_ptr_d;
            r_rd_ptr  <= w_rd_ptr_d;
            r_lane    <= w_lane_d;
            r_level   <= w_level_d;
            r_rd_data <= w_rd_data_d;
        end
    end

    assign wr_ready    = !w_full;
    assign rd_valid    = !w_empty;
    assign empty       = w_empty;
    assign rd_data     = r_rd_data;
    assign level_bytes = r_level;

`ifdef DMA_BYTE_FIFO_STATS_EN
    logic [1:0]        r_err;
    logic [1:0]        w_err_d;
    logic [ADDR_W+2:0] r_peak;
    logic [ADDR_W+2:0] w_peak_d;

    always_comb begin
        w_err_d  = r_err;
        w_peak_d = r_peak;
        if (flush) begin
            w_err_d  = '0;
            w_peak_d = '0;
        end else begin
            if (wr_valid && w_full) begin
                w_err_d[ERR_OVF] = 1'b1;
            end
            if (rd_pop && w_empty) begin
                w_err_d[ERR_UDF] = 1'b1;
            end
            if (w_level_d > r_peak) begin
                w_peak_d = w_level_d;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_err  <= '0;
            r_peak <= '0;
        end else begin
            r_err  <= w_err_d;
            r_peak <= w_peak_d;
        end
    end

    assign err_sticky = r_err;
    assign peak_level = r_peak;
`endif

endmodule
